// File: rtl/ps2_receiver_pkg.sv
// ps2_receiver_pkg: shared types and constants for the PS/2 receiver.
//   PS2_CODE_EXT / PS2_CODE_BREAK : scan-code prefixes (E0 extended, F0 break)
//   frame_state_e                 : serial frame FSM states
//   out_state_e                   : ps2_state output FSM states
//   odd_parity_ok()               : 1 when data+parity carry an odd number of ones
package ps2_receiver_pkg;

  localparam logic [7:0] PS2_CODE_EXT   = 8'hE0;
  localparam logic [7:0] PS2_CODE_BREAK = 8'hF0;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_DATA,
    FR_PARITY,
    FR_STOP
  } frame_state_e;

  typedef enum logic {
    OUT_LOW,
    OUT_HIGH
  } out_state_e;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronizes the raw PS/2 lines and deserializes 11-bit frames.
//
// state     | meaning
// ----------+-----------------------------------------------
// FR_IDLE   | waiting for a start bit (data=0 on a falling edge)
// FR_DATA   | shifting in 8 data bits, LSB first
// FR_PARITY | capturing the parity bit
// FR_STOP   | checking the stop bit, publishing the code
//
// Ports:
//   clk, rst_n         system clock, async active-low reset
//   ps2_clk, ps2_data  raw asynchronous PS/2 pins
//   code[7:0]          last received byte (valid while code_valid=1)
//   code_valid         1-clk pulse on an accepted frame
//   frame_err          1-clk pulse on a rejected frame (PS2_PARITY_CHECK_EN only)
//
// Build option: define PS2_PARITY_CHECK_EN to reject bad-parity / bad-stop
// frames with a frame_err pulse; otherwise parity is ignored and frame_err=0.
module ps2_frame_rx
  import ps2_receiver_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

`ifdef PS2_PARITY_CHECK_EN
  localparam logic PAR_CHK = 1'b1;
`else
  localparam logic PAR_CHK = 1'b0;
`endif

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    clk_sync, data_sync;
  logic          fall, data_s, frame_ok;
  frame_state_e  state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_bit, par_bit_n;
  logic [TW-1:0] tmo_cnt, tmo_cnt_n;

  // Sync flops reset to 0 so releasing reset can never fake a falling edge.
  assign fall     = clk_sync[2] & ~clk_sync[1];
  assign data_s   = data_sync[2];
  assign frame_ok = data_s & (~PAR_CHK | odd_parity_ok(shreg, par_bit));
  assign code     = shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '0;
      data_sync <= '0;
      state     <= FR_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[1:0], ps2_data};
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      par_bit   <= par_bit_n;
      tmo_cnt   <= tmo_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    par_bit_n  = par_bit;
    tmo_cnt_n  = '0;
    code_valid = 1'b0;
    frame_err  = 1'b0;
    if (state != FR_IDLE) tmo_cnt_n = tmo_cnt + 1'b1;
    if (fall) begin
      tmo_cnt_n = '0;
      case (state)
        FR_IDLE: begin
          if (!data_s) begin
            state_n   = FR_DATA;
            bit_cnt_n = '0;
          end
        end
        FR_DATA: begin
          shreg_n   = {data_s, shreg[7:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_n = FR_PARITY;
        end
        FR_PARITY: begin
          par_bit_n = data_s;
          state_n   = FR_STOP;
        end
        FR_STOP: begin
          state_n    = FR_IDLE;
          code_valid = frame_ok;
          frame_err  = ~frame_ok & PAR_CHK;
        end
        default: state_n = FR_IDLE;
      endcase
    end else if (state != FR_IDLE && tmo_cnt == TMO_LAST) begin
      // Stalled mid-frame: drop the partial frame silently.
      state_n   = FR_IDLE;
      tmo_cnt_n = '0;
    end
  end

endmodule

// File: rtl/ps2_receiver.sv
// ps2_receiver: turns PS/2 frames into a held key code plus a "key held" level
// whose low phases are long enough for a slow downstream sampler.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// OUT_LOW  | ps2_state=0; gap counter running down, rise when a code is pending
// OUT_HIGH | ps2_state=1; key {ps2_ext,ps2_byte} is held
//
// Ports:
//   clk, rst_n         system clock, async active-low reset
//   ps2_clk, ps2_data  raw asynchronous PS/2 pins
//   ps2_byte[7:0]      held scan code, prefixes stripped
//   ps2_state          1 while the key in ps2_byte is held
//   ps2_ext            1 when ps2_byte came with an E0 prefix
//   parity_err         1-clk pulse on a rejected frame
//
// Build option: PS2_PARITY_CHECK_EN (see ps2_frame_rx).
module ps2_receiver
  import ps2_receiver_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int MIN_LOW_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ps2_byte,
  output logic       ps2_state,
  output logic       ps2_ext,
  output logic       parity_err
);

  localparam int GW = $clog2(MIN_LOW_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_LOW_CYCLES);

  logic [7:0]    code;
  logic          code_valid, frame_err;
  out_state_e    out_state, out_state_n;
  logic [GW-1:0] gap_cnt, gap_cnt_n;
  logic          ext_pend, ext_pend_n, brk_pend, brk_pend_n;
  logic          pend_valid, pend_valid_n;
  logic [8:0]    pend_key, pend_key_n, held_key, held_key_n;
  logic          is_prefix, is_make, is_break;
  logic [8:0]    rx_key;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .code      (code),
    .code_valid(code_valid),
    .frame_err (frame_err)
  );

  // Keys are compared as {ext, code} so E0-75 and plain 75 stay distinct.
  assign is_prefix = (code == PS2_CODE_EXT) || (code == PS2_CODE_BREAK);
  assign is_make   = code_valid & ~is_prefix & ~brk_pend;
  assign is_break  = code_valid & ~is_prefix & brk_pend;
  assign rx_key    = {ext_pend, code};

  assign ps2_byte  = held_key[7:0];
  assign ps2_ext   = held_key[8];
  assign ps2_state = (out_state == OUT_HIGH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state  <= OUT_LOW;
      gap_cnt    <= '0;
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
      pend_valid <= 1'b0;
      pend_key   <= '0;
      held_key   <= '0;
      parity_err <= 1'b0;
    end else begin
      out_state  <= out_state_n;
      gap_cnt    <= gap_cnt_n;
      ext_pend   <= ext_pend_n;
      brk_pend   <= brk_pend_n;
      pend_valid <= pend_valid_n;
      pend_key   <= pend_key_n;
      held_key   <= held_key_n;
      parity_err <= frame_err;
    end
  end

  always_comb begin
    out_state_n  = out_state;
    gap_cnt_n    = gap_cnt;
    ext_pend_n   = ext_pend;
    brk_pend_n   = brk_pend;
    pend_valid_n = pend_valid;
    pend_key_n   = pend_key;
    held_key_n   = held_key;

    if (code_valid) begin
      if (code == PS2_CODE_EXT) begin
        ext_pend_n = 1'b1;
      end else if (code == PS2_CODE_BREAK) begin
        brk_pend_n = 1'b1;
      end else begin
        ext_pend_n = 1'b0;
        brk_pend_n = 1'b0;
      end
    end

    if (is_break && pend_valid && rx_key == pend_key) pend_valid_n = 1'b0;

    case (out_state)
      OUT_LOW: begin
        gap_cnt_n = (gap_cnt == '0) ? '0 : gap_cnt - 1'b1;
        if (is_make) begin
          pend_key_n   = rx_key;
          pend_valid_n = 1'b1;
        end
        // Rising on the decremented value gives exactly MIN_LOW_CYCLES low
        // cycles, and a make arriving with the gap expired rises next clk.
        if (gap_cnt_n == '0 && pend_valid_n) begin
          held_key_n   = pend_key_n;
          pend_valid_n = 1'b0;
          out_state_n  = OUT_HIGH;
        end
      end
      OUT_HIGH: begin
        if (is_make && rx_key != held_key) begin
          pend_key_n   = rx_key;
          pend_valid_n = 1'b1;
          gap_cnt_n    = GAP_LOAD;
          out_state_n  = OUT_LOW;
        end else if (is_break && rx_key == held_key) begin
          gap_cnt_n   = GAP_LOAD;
          out_state_n = OUT_LOW;
        end
      end
    endcase
  end

endmodule
